lsu_ctrl: RTL and testbench

Parametrised load/store unit with an integrated byte-addressable data memory. It sits between the datapath's execute stage and data storage, replacing the fixed single-cycle data memory. It executes SB/SH/SW/LB/LBU/LH/LHU/LW over a valid/ready request and a one-cycle response pulse. It adds three things the previous data memory lacked: configurable memory latency, address range checking, and optional split handling of misaligned accesses.

---
 rtl/lsu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit with byte-addressable data memory, configurable beat latency and range checking.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned and word-crossing accesses instead of rejecting them.
module lsu_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LAT        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int NB = 8;
    localparam logic [1:0] S_BEAT1 = 2'd2;
`else
    localparam int NB = 4;
`endif
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [31:0]           mem [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rdy_q;
    logic                  we_q, we_d, sgn_q, sgn_d, err_q, err_d;
    logic [1:0]            size_q, size_d, off_q, off_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [8*NB-1:0]       rd_q, rd_d;
    logic                  accept, last_beat, bad;
    logic [2:0]            nbytes;
    logic [ADDR_W-1:0]     last_addr;
    logic [3:0]            be;
    logic [NB-1:0]         wbe;
    logic [8*NB-1:0]       wd, sh;
    logic [31:0]           ext, asm_data;

    assign accept    = req_valid && req_ready;
    assign last_beat = cnt_q == 3'(LAT);
    assign nbytes    = req_size == 2'd0 ? 3'd1 : req_size == 2'd1 ? 3'd2 : 3'd4;
    assign last_addr = req_addr + ADDR_W'(nbytes - 3'd1);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic cross, cross_q, cross_d;
    assign cross = ({1'b0, req_addr[1:0]} + nbytes) > 3'd4;
    // Checking the last touched byte covers the second word of a split access.
    assign bad   = req_size == 2'd3 || (req_addr >> (DEPTH_LOG2 + 2)) != '0
                || (last_addr >> (DEPTH_LOG2 + 2)) != '0;
`else
    logic mis;
    assign mis = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    assign bad = req_size == 2'd3 || (req_addr >> (DEPTH_LOG2 + 2)) != '0
              || (last_addr >> (DEPTH_LOG2 + 2)) != '0 || mis;
`endif

    assign be       = size_q == 2'd0 ? 4'h1 : size_q == 2'd1 ? 4'h3 : 4'hF;
    assign wbe      = NB'(be) << off_q;
    assign wd       = (8*NB)'(wdata_q) << {off_q, 3'b000};
    assign sh       = rd_q >> {off_q, 3'b000};
    assign ext      = size_q == 2'd0 ? {{24{sgn_q & sh[7]}}, sh[7:0]}
                    : size_q == 2'd1 ? {{16{sgn_q & sh[15]}}, sh[15:0]} : sh[31:0];
    assign asm_data = (err_q || we_q) ? '0 : ext;

    assign req_ready = rdy_q && state_q == S_IDLE;
    assign busy      = state_q != S_IDLE;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_rdata = rsp_valid ? asm_data : rdata_q;
    assign rsp_err   = rsp_valid ? err_q : rsp_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sgn_d     = sgn_q;
        err_d     = err_q;
        size_d    = size_q;
        off_d     = off_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        rd_d      = rd_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        cross_d   = cross_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = bad ? S_RESP : S_BEAT0;
                cnt_d   = '0;
                we_d    = req_we;
                sgn_d   = req_signed;
                err_d   = bad;
                size_d  = req_size;
                off_d   = req_addr[1:0];
                idx_d   = req_addr[DEPTH_LOG2+1:2];
                wdata_d = req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                cross_d = cross;
`endif
            end
            S_BEAT0: begin
                cnt_d = last_beat ? '0 : cnt_q + 3'd1;
                if (last_beat) begin
                    rd_d[31:0] = mem[idx_q];
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d    = cross_q ? S_BEAT1 : S_RESP;
`else
                    state_d    = S_RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_BEAT1: begin
                cnt_d = last_beat ? '0 : cnt_q + 3'd1;
                if (last_beat) begin
                    rd_d[63:32] = mem[idx_q + DEPTH_LOG2'(1)];
                    state_d     = S_RESP;
                end
            end
`endif
            default: begin
                state_d   = S_IDLE;
                rdata_d   = asm_data;
                rsp_err_d = err_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
            rd_q      <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdy_q     <= 1'b1;
            we_q      <= we_d;
            sgn_q     <= sgn_d;
            err_q     <= err_d;
            size_q    <= size_d;
            off_q     <= off_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
            rd_q      <= rd_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_q   <= cross_d;
`endif
        end
    end

    // Writes commit on the last cycle of their beat; reset forces IDLE so an aborted beat never writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_q && last_beat && state_q == S_BEAT0 && wbe[i]) mem[idx_q][8*i +: 8] <= wd[8*i +: 8];
`ifdef LSU_MISALIGN_SPLIT_EN
            if (we_q && last_beat && state_q == S_BEAT1 && wbe[4+i])
                mem[idx_q + DEPTH_LOG2'(1)][8*i +: 8] <= wd[32+8*i +: 8];
`endif
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl (LAT=1, DEPTH_LOG2=8).
// Follows LSU_MISALIGN_SPLIT_EN when it is defined for the build.
module tb_lsu_ctrl;
    localparam int LAT = 1;
    localparam int TMO = 50;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, req_signed = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DEPTH_LOG2(8), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    // Drives one request; lat counts cycles from the accepting cycle to the rsp_valid cycle.
    task automatic xfer(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int w = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        while (!req_ready && w < TMO) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 0; req_we = ~we; req_size = 2'd3; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!rsp_valid && lat < TMO) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_rdata, rsp_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_aligned;
        logic [31:0] rd; logic er; int lat;
        xfer(1, 2'd2, 0, 32'h10, 32'h8765_4321, rd, er, lat);
        tests++; if (er !== 0 || rd !== 0 || lat != LAT + 2) begin fails++; $display("FAIL sw got err %b rd %h lat %0d exp 0 0 %0d", er, rd, lat, LAT + 2); end
        xfer(0, 2'd0, 0, 32'h11, 0, rd, er, lat);
        tests++; if (rd !== 32'h43 || er !== 0 || lat != LAT + 2) begin fails++; $display("FAIL lbu got %h lat %0d exp 00000043 %0d", rd, lat, LAT + 2); end
        xfer(0, 2'd0, 1, 32'h13, 0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_FF87 || lat != LAT + 2) begin fails++; $display("FAIL lb got %h lat %0d exp ffffff87 %0d", rd, lat, LAT + 2); end
        xfer(0, 2'd1, 0, 32'h12, 0, rd, er, lat);
        tests++; if (rd !== 32'h0000_8765 || lat != LAT + 2) begin fails++; $display("FAIL lhu got %h lat %0d exp 00008765 %0d", rd, lat, LAT + 2); end
        xfer(0, 2'd1, 1, 32'h12, 0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_8765) begin fails++; $display("FAIL lh got %h exp ffff8765", rd); end
        xfer(0, 2'd2, 0, 32'h10, 0, rd, er, lat);
        tests++; if (rd !== 32'h8765_4321 || lat != LAT + 2) begin fails++; $display("FAIL lw got %h lat %0d exp 87654321 %0d", rd, lat, LAT + 2); end
    endtask

    task automatic test_merge;
        logic [31:0] rd; logic er; int lat;
        xfer(1, 2'd2, 0, 32'h20, 32'h0, rd, er, lat);
        xfer(1, 2'd0, 0, 32'h22, 32'hFFFF_FFAA, rd, er, lat);
        xfer(1, 2'd1, 0, 32'h20, 32'h1234_BEEF, rd, er, lat);
        xfer(0, 2'd2, 0, 32'h20, 0, rd, er, lat);
        tests++; if (rd !== 32'h00AA_BEEF) begin fails++; $display("FAIL merge got %h exp 00aabeef", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        xfer(0, 2'd3, 0, 32'h10, 0, rd, er, lat);
        tests++; if (er !== 1 || rd !== 0 || lat != 1) begin fails++; $display("FAIL size11 got err %b rd %h lat %0d exp 1 0 1", er, rd, lat); end
        @(negedge clk);
        tests++; if (rsp_valid !== 0 || rsp_err !== 1) begin fails++; $display("FAIL err_hold got valid %b err %b exp 0 1", rsp_valid, rsp_err); end
        xfer(1, 2'd2, 0, 32'h0, 32'h1234_5678, rd, er, lat);
        xfer(1, 2'd2, 0, 32'h400, 32'hDEAD_BEEF, rd, er, lat);
        tests++; if (er !== 1 || lat != 1) begin fails++; $display("FAIL sw_oor got err %b lat %0d exp 1 1", er, lat); end
        xfer(0, 2'd2, 0, 32'h400, 0, rd, er, lat);
        tests++; if (er !== 1 || rd !== 0) begin fails++; $display("FAIL lw_oor got err %b rd %h exp 1 0", er, rd); end
        xfer(0, 2'd2, 0, 32'h0, 0, rd, er, lat);
        tests++; if (er !== 0 || rd !== 32'h1234_5678) begin fails++; $display("FAIL oor_nowrite got %h exp 12345678", rd); end
        xfer(0, 2'd2, 0, 32'h3FE, 0, rd, er, lat);
        tests++; if (er !== 1 || lat != 1) begin fails++; $display("FAIL lw_3fe got err %b lat %0d exp 1 1", er, lat); end
        xfer(0, 2'd2, 0, 32'h3FC, 0, rd, er, lat);
        tests++; if (er !== 0 || lat != LAT + 2) begin fails++; $display("FAIL lw_3fc got err %b lat %0d exp 0 %0d", er, lat, LAT + 2); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic er; int lat;
        xfer(1, 2'd2, 0, 32'h14, 32'hAAAA_AAAA, rd, er, lat);
        xfer(1, 2'd2, 0, 32'h18, 32'hBBBB_BBBB, rd, er, lat);
        xfer(1, 2'd2, 0, 32'h17, 32'h1122_3344, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
        tests++; if (er !== 0 || lat != 2 * LAT + 3) begin fails++; $display("FAIL sw_split got err %b lat %0d exp 0 %0d", er, lat, 2 * LAT + 3); end
        xfer(0, 2'd2, 0, 32'h14, 0, rd, er, lat);
        tests++; if (rd !== 32'h44AA_AAAA) begin fails++; $display("FAIL split_w0 got %h exp 44aaaaaa", rd); end
        xfer(0, 2'd2, 0, 32'h18, 0, rd, er, lat);
        tests++; if (rd !== 32'hBB11_2233) begin fails++; $display("FAIL split_w1 got %h exp bb112233", rd); end
        xfer(0, 2'd2, 0, 32'h17, 0, rd, er, lat);
        tests++; if (er !== 0 || rd !== 32'h1122_3344 || lat != 2 * LAT + 3) begin fails++; $display("FAIL lw_split got %h lat %0d exp 11223344 %0d", rd, lat, 2 * LAT + 3); end
        xfer(0, 2'd1, 0, 32'h15, 0, rd, er, lat);
        tests++; if (er !== 0 || rd !== 32'h0000_AAAA || lat != LAT + 2) begin fails++; $display("FAIL lhu_15 got %h lat %0d exp 0000aaaa %0d", rd, lat, LAT + 2); end
`else
        tests++; if (er !== 1 || rd !== 0 || lat != 1) begin fails++; $display("FAIL sw_mis got err %b rd %h lat %0d exp 1 0 1", er, rd, lat); end
        xfer(0, 2'd2, 0, 32'h14, 0, rd, er, lat);
        tests++; if (rd !== 32'hAAAA_AAAA) begin fails++; $display("FAIL mis_w0 got %h exp aaaaaaaa", rd); end
        xfer(0, 2'd2, 0, 32'h18, 0, rd, er, lat);
        tests++; if (rd !== 32'hBBBB_BBBB) begin fails++; $display("FAIL mis_w1 got %h exp bbbbbbbb", rd); end
        xfer(0, 2'd1, 0, 32'h15, 0, rd, er, lat);
        tests++; if (er !== 1 || lat != 1) begin fails++; $display("FAIL lhu_15 got err %b lat %0d exp 1 1", er, lat); end
`endif
    endtask

    task automatic test_back_to_back;
        int acc = 0, acc2 = -1, nrsp = 0;
        logic rdy_low = 1, busy_ok = 1;
        logic [31:0] r0 = 0, r1 = 0;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h10;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) req_addr = 32'h20;
            if (c == LAT + 4) req_valid = 0;
            if (req_valid && req_ready) begin acc++; if (c > 0) acc2 = c; end
            if (c >= 1 && c <= LAT + 2 && (req_ready || !busy)) begin rdy_low = 0; busy_ok = 0; end
            if (rsp_valid) begin if (nrsp == 0) r0 = rsp_rdata; else r1 = rsp_rdata; nrsp++; end
            @(negedge clk);
        end
        tests++; if (!rdy_low || !busy_ok) begin fails++; $display("FAIL busy_ready got ready-low %b busy %b exp 1 1", rdy_low, busy_ok); end
        tests++; if (acc != 2 || acc2 != LAT + 3) begin fails++; $display("FAIL accepts got %0d at %0d exp 2 at %0d", acc, acc2, LAT + 3); end
        tests++; if (nrsp != 2 || r0 !== 32'h8765_4321 || r1 !== 32'h00AA_BEEF) begin fails++; $display("FAIL b2b_rsp got %0d %h %h exp 2 87654321 00aabeef", nrsp, r0, r1); end
        tests++; if (rsp_valid !== 0 || rsp_rdata !== 32'h00AA_BEEF) begin fails++; $display("FAIL rdata_hold got %b %h exp 0 00aabeef", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat; int seen = 0;
`ifdef LSU_MISALIGN_SPLIT_EN
        xfer(1, 2'd2, 0, 32'h30, 32'h0, rd, er, lat);
        xfer(1, 2'd2, 0, 32'h34, 32'h0, rd, er, lat);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h33; req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 0;
        repeat (LAT + 1) @(negedge clk);
`else
        xfer(1, 2'd2, 0, 32'h30, 32'h5555_5555, rd, er, lat);
        xfer(0, 2'd2, 0, 32'h30, 0, rd, er, lat);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h6666_6666;
        @(negedge clk);
        req_valid = 0;
`endif
        tests++; if (busy !== 1) begin fails++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst_n = 0;
        #1;
        tests++; if (req_ready !== 0 || busy !== 0 || rsp_valid !== 0) begin fails++; $display("FAIL mid_reset_ctl got rdy %b busy %b valid %b exp 0 0 0", req_ready, busy, rsp_valid); end
        tests++; if (rsp_rdata !== 0 || rsp_err !== 0) begin fails++; $display("FAIL mid_reset_rsp got %h %b exp 0 0", rsp_rdata, rsp_err); end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 8; c++) begin if (rsp_valid) seen++; @(negedge clk); end
        tests++; if (seen != 0) begin fails++; $display("FAIL mid_no_rsp got %0d exp 0", seen); end
`ifdef LSU_MISALIGN_SPLIT_EN
        xfer(0, 2'd2, 0, 32'h30, 0, rd, er, lat);
        tests++; if (rd !== 32'h4400_0000) begin fails++; $display("FAIL mid_beat0 got %h exp 44000000", rd); end
        xfer(0, 2'd2, 0, 32'h34, 0, rd, er, lat);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mid_beat1 got %h exp 00000000", rd); end
`else
        xfer(0, 2'd2, 0, 32'h30, 0, rd, er, lat);
        tests++; if (rd !== 32'h5555_5555) begin fails++; $display("FAIL mid_nowrite got %h exp 55555555", rd); end
`endif
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_merge;
        test_errors;
        test_misalign;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
